// File: rtl/alu_apb_cmd_master.sv
// rtl/alu_apb_cmd_master.sv - buffered ALU command issuer: APB write, optional settle + read-back, one response per command
module alu_apb_cmd_master #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_word,
  input  logic        cmd_readback,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WSETUP, S_WACCESS, S_SETTLE, S_RSETUP, S_RACCESS, S_RESP
  } state_t;

  state_t state, state_next;

  logic [32:0]   fifo_mem [FIFO_DEPTH];
  logic [32:0]   fifo_head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_count;
  logic          fifo_empty, fifo_full, push, pop;

  logic [31:0]   word_q;
  logic          rb_q;
  logic          err_q;
  logic [31:0]   data_q;
  logic [CW-1:0] cnt;
  logic          access, timeout_hit, settle_done, bad_addr;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign fifo_head  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_readback, cmd_word};
  end

  assign access      = (state == S_WACCESS) || (state == S_RACCESS);
  assign timeout_hit = access && !pready && (cnt == CW'(TIMEOUT - 1));
  assign settle_done = (cnt == CW'(SETTLE_CYCLES - 1));
  assign bad_addr    = (word_q[5:0] > 6'd15);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    psel       = 1'b0;
    penable    = 1'b0;
    pwrite     = 1'b0;
    paddr      = '0;
    pwdata     = '0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    unique case (state)
      S_IDLE: if (!fifo_empty) state_next = S_WSETUP;
      S_WSETUP: begin
        psel       = 1'b1;
        pwrite     = 1'b1;
        pwdata     = word_q;
        state_next = S_WACCESS;
      end
      S_WACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        pwdata  = word_q;
        // Slave error wins over write-only, which wins over an out-of-range read address.
        if (pready) state_next = (pslverr || !rb_q || bad_addr) ? S_RESP : S_SETTLE;
        else if (timeout_hit) state_next = S_RESP;
      end
      S_SETTLE: if (settle_done) state_next = S_RSETUP;
      S_RSETUP: begin
        psel       = 1'b1;
        paddr      = {26'b0, word_q[5:0]};
        state_next = S_RACCESS;
      end
      S_RACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        paddr   = {26'b0, word_q[5:0]};
        if (pready || timeout_hit) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = data_q;
        rsp_err   = err_q;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      rb_q   <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      if (state_next != state)                cnt <= '0;
      else if (access || state == S_SETTLE)   cnt <= cnt + 1'b1;

      if (pop) begin
        word_q <= fifo_head[31:0];
        rb_q   <= fifo_head[32];
        err_q  <= 1'b0;
        data_q <= '0;
      end
      if (state == S_WACCESS && pready) err_q <= pslverr || (rb_q && bad_addr);
      if (state == S_RACCESS && pready) begin
        err_q  <= err_q || pslverr;
        data_q <= (err_q || pslverr) ? 32'h0 : prdata;
      end
      if (timeout_hit) begin
        err_q  <= 1'b1;
        data_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_apb_cmd_master.sv
// tb/tb_alu_apb_cmd_master.sv - scoreboard bench for alu_apb_cmd_master with a behavioural APB slave
module tb_alu_apb_cmd_master;
  localparam int SETTLE = 4;
  localparam int TMO    = 16;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_readback = 1'b0, rsp_ready = 1'b1;
  logic [31:0] cmd_word = 32'h0;
  logic        cmd_ready, rsp_valid, rsp_err, busy;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] rsp_data, paddr, pwdata, prdata;

  logic        stall_all = 1'b0, stall_rd = 1'b0, err_wr = 1'b0, err_rd = 1'b0;
  logic [31:0] tbl [16];

  typedef struct packed { logic [31:0] data; logic err; } rsp_t;
  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] wdata; } apb_t;
  rsp_t rsp_q[$];
  apb_t apb_q[$];

  int checks = 0, errors = 0, cyc = 0;

  alu_apb_cmd_master #(.FIFO_DEPTH(4), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word), .cmd_readback(cmd_readback),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pready  = !(stall_all || (stall_rd && !pwrite));
  assign pslverr = psel && penable && (pwrite ? err_wr : err_rd);
  assign prdata  = tbl[paddr[3:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic rb, input logic exp_rsp,
                      input logic [31:0] ed, input logic ee, input logic ew, input logic er);
    int n = 0;
    cmd_word = w; cmd_readback = rb; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("push_accept", 32'(cmd_ready), 32'd1);
    if (cmd_ready) begin
      if (exp_rsp) rsp_q.push_back('{data: ed, err: ee});
      if (ew) apb_q.push_back('{wr: 1'b1, addr: 32'h0, wdata: w});
      if (er) apb_q.push_back('{wr: 1'b0, addr: {26'b0, w[5:0]}, wdata: 32'h0});
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || rsp_q.size() != 0) && n < 400);
    check("drain", 32'(busy || rsp_q.size() != 0), 32'd0);
    @(posedge clk); #1;
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got data=%h err=%b with nothing expected", rsp_data, rsp_err);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // APB monitor: transfer contents, setup-before-access, drop-after-ready, settle gap
  logic prev_psel = 1'b0, prev_pen = 1'b0, prev_rdy = 1'b0;
  int   last_wr_cyc = 0;
  always @(negedge clk) begin
    if (psel && penable && !(prev_psel && prev_pen))
      check("setup_before_access", 32'(prev_psel && !prev_pen), 32'd1);
    if (prev_psel && prev_pen && prev_rdy)
      check("psel_drop_after_ready", 32'(psel), 32'd0);
    if (psel && !penable && !pwrite)
      check("settle_gap", 32'(cyc - last_wr_cyc - 1), 32'(SETTLE));
    if (psel && penable && pready) begin
      if (pwrite) last_wr_cyc = cyc;
      if (apb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL apb_unexpected: got pwrite=%b paddr=%h with nothing expected", pwrite, paddr);
      end else begin
        apb_t e;
        e = apb_q.pop_front();
        check("apb_dir", 32'(pwrite), 32'(e.wr));
        check("apb_addr", paddr, e.addr);
        if (e.wr) check("apb_wdata", pwdata, e.wdata);
      end
    end
    prev_psel = psel; prev_pen = penable; prev_rdy = pready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, w;
    for (int i = 0; i < 16; i++) tbl[i] = 32'h1000 + i;
    tbl[2] = 32'h8; tbl[3] = 32'h55; tbl[15] = 32'hDEADBEEF;

    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_apb_ctl", {29'b0, psel, penable, pwrite}, 32'd0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp", rsp_data | 32'(rsp_err), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Read-back with response back-pressure
    rsp_ready = 1'b0;
    push(32'h1000C142, 1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1);
    w = 0;
    while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (3) @(negedge clk);
    check("t1_hold_valid", 32'(rsp_valid), 32'd1);
    check("t1_hold_data", rsp_data, 32'h8);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle();

    // Write-only, then address boundaries 0x20, 16, 15
    push(32'h1000C142, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    push(32'h1000C160, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    push(32'h1000C150, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    push(32'h1000C14F, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Slave errors on the write and on the read
    err_wr = 1'b1;
    push(32'h1000C144, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    wait_idle();
    err_wr = 1'b0; err_rd = 1'b1;
    push(32'h1000C145, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
    wait_idle();
    err_rd = 1'b0;

    // Write timeout, then the queued command completes normally
    stall_all = 1'b1;
    push(32'h30000001, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    push(32'h1000C143, 1'b1, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1);
    n = 0; w = 0;
    @(negedge clk);
    while (!(psel && penable) && w < 50) begin @(negedge clk); w++; end
    while (psel && penable && n < 100) begin n++; @(negedge clk); end
    check("timeout_access_cycles", 32'(n), 32'(TMO));
    stall_all = 1'b0;
    wait_idle();

    // Fill the FIFO behind a stalled write; five ordered responses
    stall_all = 1'b1;
    push(32'h1000C143, 1'b1, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1);
    push(32'h40001234, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    push(32'h1000C14F, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    push(32'h1000C17F, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    push(32'h50000000, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b1);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    check("full_hold_ready", 32'(cmd_ready), 32'd0);
    stall_all = 1'b0;
    wait_idle();

    // Asynchronous reset during a stalled read with two commands queued
    stall_rd = 1'b1;
    push(32'h1000C142, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    push(32'h20000004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    push(32'h20000005, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (!(psel && penable && !pwrite) && w < 100) begin @(negedge clk); w++; end
    check("reached_raccess", 32'(psel && penable && !pwrite), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_psel", 32'(psel), 32'd0);
    check("arst_penable", 32'(penable), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    stall_rd = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    push(32'h1000C14F, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    wait_idle();

    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("apb_queue_empty", 32'(apb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
